seg7_scan_driver: RTL and testbench

Output-side counterpart to the push-button input conditioning: drives a multiplexed common-anode 7-segment display on the FPGA board from a hex value supplied by the emulator/debugger core. It time-multiplexes DIGITS digits using a refresh prescaler and inserts dead time between digits to prevent ghosting. New values are double-buffered and committed only at frame boundaries, so the display never tears. All pin outputs are registered.

---
 rtl/seg7_pkg.sv | 18 +
 rtl/seg7_scan_driver_hex_decode.sv | 11 +
 rtl/seg7_scan_driver.sv | 150 +++++++++++++++
 tb/tb_seg7_scan_driver.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: active-low hex segment table
// and the helper that picks one digit's nibble out of a packed value word.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns for 0..F
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Up to 8 digits: vals is the zero-extended nibble vector, idx the digit
  function automatic logic [3:0] sel_nibble(input logic [31:0] vals, input logic [2:0] idx);
    return vals[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/seg7_scan_driver_hex_decode.sv
// Combinational nibble to active-low segment decode; the caller registers it.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_c
);

  assign seg_c = SEG_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode 7-segment driver with per-slot dead time and
// frame-synchronous double buffering. Optional: SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_tick
);

  localparam int unsigned PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned VAL_W = 4 * DIGITS;

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [VAL_W-1:0]  stage_val_q, stage_val_d;
  logic [DIGITS-1:0] stage_dp_q, stage_dp_d;
  logic [VAL_W-1:0]  shadow_val_q, shadow_val_d;
  logic [DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic              pending_q, pending_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic              frame_tick_q, frame_tick_d;

  logic              pre_term_c;
  logic              frame_end_c;
  logic              blank_phase_c;
  logic              lz_blank_c;
  logic [3:0]        nib_c;
  logic [6:0]        dec_seg_c;

  assign pre_term_c    = (pre_q == PRE_W'(REFRESH_DIV - 1));
  assign frame_end_c   = pre_term_c && (idx_q == IDX_W'(DIGITS - 1));
  assign blank_phase_c = (pre_q < PRE_W'(BLANK_CYCLES));
  assign nib_c         = sel_nibble(32'(shadow_val_q), 3'(idx_q));

  seg7_hex_decode u_dec (
    .nibble (nib_c),
    .seg_c  (dec_seg_c)
  );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] zero_above_c;

  // zero_above_c[i]: nibble i and every higher nibble of the shadow are zero
  always_comb begin
    logic run;
    run          = 1'b1;
    zero_above_c = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run             = run && (shadow_val_q[4*i +: 4] == 4'h0);
      zero_above_c[i] = run;
    end
  end

  assign lz_blank_c = zero_above_c[idx_q] && (idx_q != '0);
`else
  assign lz_blank_c = 1'b0;
`endif

  // Next-state: prescaler, digit index, staging/shadow buffers, pin values
  always_comb begin
    pre_d        = pre_q + PRE_W'(1);
    idx_d        = idx_q;
    stage_val_d  = stage_val_q;
    stage_dp_d   = stage_dp_q;
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    pending_d    = pending_q;
    an_d         = '1;
    seg_d        = SEG_OFF;
    dp_d         = 1'b1;
    frame_tick_d = frame_end_c;

    if (pre_term_c) begin
      pre_d = '0;
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end

    if (load) begin
      stage_val_d = value;
      stage_dp_d  = dp_in;
      pending_d   = 1'b1;
    end

    // A load coinciding with the boundary bypasses staging
    if (frame_end_c) begin
      pending_d = 1'b0;
      if (load) begin
        shadow_val_d = value;
        shadow_dp_d  = dp_in;
      end else if (pending_q) begin
        shadow_val_d = stage_val_q;
        shadow_dp_d  = stage_dp_q;
      end
    end

    if (!blank_phase_c) begin
      an_d  = ~(DIGITS'(1) << idx_q);
      seg_d = lz_blank_c ? SEG_OFF : dec_seg_c;
      dp_d  = ~shadow_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q        <= '0;
      idx_q        <= '0;
      stage_val_q  <= '0;
      stage_dp_q   <= '0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      pending_q    <= 1'b0;
      an_q         <= '1;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      pre_q        <= pre_d;
      idx_q        <= idx_d;
      stage_val_q  <= stage_val_d;
      stage_dp_q   <= stage_dp_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      pending_q    <= pending_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver (DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1):
// per-cycle scoreboard plus directed per-frame checks.
module tb_seg7_scan_driver;

  localparam int D  = 4;
  localparam int RD = 4;
  localparam int BC = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        load;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  seg7_scan_driver #(.DIGITS(D), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .dp_in      (dp_in),
    .load       (load),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ft;
  } pins_t;

  pins_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  // reference model state
  int          m_pre, m_idx;
  logic [15:0] m_sv, m_st;
  logic [3:0]  m_sd, m_stdp;
  bit          m_pend;

  // observation state
  logic [6:0]  last_seg [4];
  logic        last_dp  [4];
  logic [3:0]  an_seq[$];
  logic [3:0]  prev_an;
  bit          last_ft;
  bit          saw_one;
  int          tick_cnt;
  int          step_no;
  int          first_tick_step;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  task automatic model_reset();
    m_pre = 0; m_idx = 0; m_sv = '0; m_st = '0; m_sd = '0; m_stdp = '0; m_pend = 0;
  endtask

  // Predict pins after the coming edge, then advance model state across it
  task automatic model_push();
    pins_t e;
    logic [15:0] above;
    bit boundary;
    boundary = (m_pre == RD - 1) && (m_idx == D - 1);
    e.ft = boundary;
    if (m_pre < BC) begin
      e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1;
    end else begin
      e.an  = ~(4'b0001 << m_idx);
      e.seg = hex7(m_sv[m_idx*4 +: 4]);
      e.dp  = ~m_sd[m_idx];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      above = m_sv >> (m_idx * 4);
      if (m_idx != 0 && above == 16'h0) e.seg = 7'h7F;
`else
      above = '0;
`endif
    end
    exp_q.push_back(e);
    if (boundary) begin
      if (load) begin
        m_sv = value; m_sd = dp_in; m_st = value; m_stdp = dp_in;
      end else if (m_pend) begin
        m_sv = m_st; m_sd = m_stdp;
      end
      m_pend = 0;
    end else if (load) begin
      m_st = value; m_stdp = dp_in; m_pend = 1;
    end
    if (m_pre == RD - 1) begin
      m_pre = 0;
      m_idx = (m_idx == D - 1) ? 0 : m_idx + 1;
    end else begin
      m_pre = m_pre + 1;
    end
  endtask

  task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] d);
    pins_t obs, e;
    @(negedge clk);
    step_no++;
    obs = {an, seg, dp, frame_tick};
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("scoreboard", 32'(obs), 32'(e));
    end
    last_ft = frame_tick;
    if (frame_tick) begin
      tick_cnt++;
      if (first_tick_step < 0) first_tick_step = step_no;
    end
    for (int i = 0; i < 4; i++) begin
      if (!an[i]) begin
        last_seg[i] = seg;
        last_dp[i]  = dp;
      end
    end
    if (an != 4'hF && prev_an == 4'hF) an_seq.push_back(an);
    if (an != 4'hF && seg == 7'h79) saw_one = 1;
    prev_an = an;
    load = ld; value = v; dp_in = d;
    model_push();
  endtask

  task automatic run_to_tick();
    bit got;
    got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      step(1'b0, 16'h0, 4'h0);
      got = last_ft;
    end
    check("tick_timeout", 32'(got), 32'd1);
  endtask

  // segs packed {d3,d2,d1,d0}; dps are the expected dp pin values
  task automatic check_frame(input string tag, input logic [27:0] segs, input logic [3:0] dps);
    run_to_tick();
    for (int i = 0; i < 4; i++) begin
      last_seg[i] = 'x;
      last_dp[i]  = 'x;
    end
    repeat (16) step(1'b0, 16'h0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_seg_d%0d", tag, i), 32'(last_seg[i]), 32'(segs[i*7 +: 7]));
      check($sformatf("%s_dp_d%0d", tag, i), 32'(last_dp[i]), 32'(dps[i]));
    end
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; value = '0; dp_in = '0;
    prev_an = 4'hF; last_ft = 0; saw_one = 0; tick_cnt = 0; step_no = 0;
    first_tick_step = -1;
    model_reset();

    // reset state
    repeat (3) @(negedge clk);
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp), 32'h1);
    check("rst_ft", 32'(frame_tick), 32'h0);

    // release and scan with no load
    rst_n = 1'b1;
    model_push();
    repeat (64) step(1'b0, 16'h0, 4'h0);
    check("tick_count", 32'(tick_cnt), 32'd4);
    check("first_tick_step", 32'(first_tick_step), 32'd16);
    check("an_seq0", 32'(an_seq[0]), 32'hE);
    check("an_seq1", 32'(an_seq[1]), 32'hD);
    check("an_seq2", 32'(an_seq[2]), 32'hB);
    check("an_seq3", 32'(an_seq[3]), 32'h7);
    for (int i = 0; i < 4; i++) check($sformatf("idle_seg_d%0d", i), 32'(last_seg[i]), 32'h40);

    // mid-frame load, committed at the next boundary
    run_to_tick();
    repeat (6) step(1'b0, 16'h0, 4'h0);
    step(1'b1, 16'h12AF, 4'b0100);
    check_frame("f12AF", {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1011);

    // two loads in one frame: last wins
    run_to_tick();
    repeat (3) step(1'b0, 16'h0, 4'h0);
    step(1'b1, 16'h1111, 4'h0);
    repeat (4) step(1'b0, 16'h0, 4'h0);
    step(1'b1, 16'h2222, 4'h0);
    run_to_tick();
    saw_one = 0;
    repeat (16) step(1'b0, 16'h0, 4'h0);
    check("no_1111_shown", 32'(saw_one), 32'd0);
    for (int i = 0; i < 4; i++) check($sformatf("f2222_seg_d%0d", i), 32'(last_seg[i]), 32'h24);

    // load exactly on the boundary edge
    run_to_tick();
    repeat (14) step(1'b0, 16'h0, 4'h0);
    step(1'b1, 16'hBEEF, 4'h0);
    step(1'b0, 16'h0, 4'h0);
    check("boundary_tick", 32'(last_ft), 32'd1);
    check("boundary_pending", 32'(dut.pending_q), 32'd0);
    check_frame("fBEEF", {7'h03, 7'h06, 7'h06, 7'h0E}, 4'b1111);

    // async reset during digit 2 active phase
    run_to_tick();
    repeat (10) step(1'b0, 16'h0, 4'h0);
    check("pre_rst_an", 32'(an), 32'hB);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_an", 32'(an), 32'hF);
    check("async_rst_seg", 32'(seg), 32'h7F);
    check("async_rst_dp", 32'(dp), 32'h1);
    exp_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    load = 1'b0;
    prev_an = 4'hF;
    model_push();
    repeat (2) step(1'b0, 16'h0, 4'h0);
    check("post_rst_an", 32'(an), 32'hE);
    check("post_rst_seg", 32'(seg), 32'h40);

    // leading-zero value
    repeat (3) step(1'b0, 16'h0, 4'h0);
    step(1'b1, 16'h0070, 4'h0);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    check_frame("f0070", {7'h7F, 7'h7F, 7'h78, 7'h40}, 4'b1111);
`else
    check_frame("f0070", {7'h40, 7'h40, 7'h78, 7'h40}, 4'b1111);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
